// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: IDLE -> REQ -> DONE handshake that stalls the pipeline.
// Optional REQ timeout with a sticky error flag is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYCLES must be within 1..255");
    end

`ifdef MEM_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

    state_t state_q, state_d;
    logic   access;

    assign access = mem_read_i | mem_write_i;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q;
    logic       err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stall is gated by rst_n so every output reads 0 while reset is held
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = access & rst_n;
                if (access) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (dmem_ack_i) begin
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ERR;
                end
`endif
            end
            DONE: state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
            ERR:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // request/address/data registers; the write flag doubles as "this access is a store"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'h0;
            dmem_wdata_o <= 32'h0;
            rdata_o      <= 32'h0;
        end else begin
            dmem_req_o <= (state_d == REQ);
            if (state_q == IDLE && access) begin
                dmem_addr_o  <= addr_i;
                dmem_wdata_o <= wdata_i;
                dmem_we_o    <= mem_write_i;
            end
            if (state_q == REQ && dmem_ack_i && !dmem_we_o) begin
                rdata_o <= dmem_rdata_i;
            end
`ifdef MEM_TIMEOUT_EN
            if (state_d == ERR) begin
                rdata_o <= 32'h0;
            end
`endif
        end
    end

`ifdef MEM_TIMEOUT_EN
    // counter holds the number of REQ cycles already elapsed without ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'h0;
            err_q     <= 1'b0;
        end else begin
            if (state_d == REQ && state_q != REQ) begin
                tmo_cnt_q <= 8'h0;
            end else if (state_q == REQ) begin
                tmo_cnt_q <= tmo_cnt_q + 8'h1;
            end
            if (state_q == REQ && state_d == ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, back-to-back, reset mid-access, read+write,
// plus timeout/error behaviour when MEM_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 3).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        addr_i = 32'h0;
        wdata_i = 32'h0;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("rst_we",    {31'h0, dmem_we_o},  32'h0);
        chk("rst_addr",  dmem_addr_o,         32'h0);
        chk("rst_wdata", dmem_wdata_o,        32'h0);
        chk("rst_rdata", rdata_o,             32'h0);
        chk("rst_stall", {31'h0, stall_o},    32'h0);
        chk("rst_err",   {31'h0, err_o},      32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Load 0x10, ack on first REQ cycle
        mem_read_i = 1'b1;
        addr_i = 32'h10;
        #1;
        chk("ld_idle_stall", {31'h0, stall_o},    32'h1);
        chk("ld_idle_req",   {31'h0, dmem_req_o}, 32'h0);
        tick();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hCAFE0001;
        #1;
        chk("ld_req_req",   {31'h0, dmem_req_o}, 32'h1);
        chk("ld_req_stall", {31'h0, stall_o},    32'h1);
        chk("ld_req_addr",  dmem_addr_o,         32'h10);
        chk("ld_req_we",    {31'h0, dmem_we_o},  32'h0);
        tick();
        dmem_ack_i = 1'b0;
        #1;
        chk("ld_done_stall", {31'h0, stall_o},    32'h0);
        chk("ld_done_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("ld_done_rdata", rdata_o,             32'hCAFE0001);
        tick();
        mem_read_i = 1'b0;
        #1;
        chk("ld_idle2_stall", {31'h0, stall_o},    32'h0);
        chk("ld_idle2_req",   {31'h0, dmem_req_o}, 32'h0);

        // Store 0x20 <- 0x12345678, ack on 4th REQ cycle, inputs disturbed while stalled
        mem_write_i = 1'b1;
        addr_i = 32'h20;
        wdata_i = 32'h12345678;
        #1;
        chk("st_idle_stall", {31'h0, stall_o}, 32'h1);
        tick();
        addr_i = 32'hFFFFFFFF;
        wdata_i = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) begin
                dmem_ack_i = 1'b1;
                dmem_rdata_i = 32'hBAD0BAD0;
            end
            #1;
            chk($sformatf("st_req%0d_req", i),   {31'h0, dmem_req_o}, 32'h1);
            chk($sformatf("st_req%0d_stall", i), {31'h0, stall_o},    32'h1);
            chk($sformatf("st_req%0d_we", i),    {31'h0, dmem_we_o},  32'h1);
            chk($sformatf("st_req%0d_addr", i),  dmem_addr_o,         32'h20);
            chk($sformatf("st_req%0d_wdata", i), dmem_wdata_o,        32'h12345678);
            tick();
        end
        dmem_ack_i = 1'b0;
        mem_write_i = 1'b0;
        #1;
        chk("st_done_stall", {31'h0, stall_o},    32'h0);
        chk("st_done_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("st_done_rdata", rdata_o,             32'hCAFE0001);
        tick();

        // Back-to-back load 0x30 then store 0x34
        mem_read_i = 1'b1;
        addr_i = 32'h30;
        tick();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h11112222;
        #1;
        chk("b2b_ld_req",  {31'h0, dmem_req_o}, 32'h1);
        chk("b2b_ld_addr", dmem_addr_o,         32'h30);
        tick();
        dmem_ack_i = 1'b0;
        mem_read_i = 1'b0;
        mem_write_i = 1'b1;
        addr_i = 32'h34;
        wdata_i = 32'hA5A5A5A5;
        #1;
        chk("b2b_done_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("b2b_done_stall", {31'h0, stall_o},    32'h0);
        chk("b2b_done_rdata", rdata_o,             32'h11112222);
        tick();
        #1;
        chk("b2b_idle_stall", {31'h0, stall_o},    32'h1);
        chk("b2b_idle_req",   {31'h0, dmem_req_o}, 32'h0);
        tick();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h44444444;
        #1;
        chk("b2b_st_req",   {31'h0, dmem_req_o}, 32'h1);
        chk("b2b_st_addr",  dmem_addr_o,         32'h34);
        chk("b2b_st_we",    {31'h0, dmem_we_o},  32'h1);
        chk("b2b_st_wdata", dmem_wdata_o,        32'hA5A5A5A5);
        tick();
        dmem_ack_i = 1'b0;
        mem_write_i = 1'b0;
        #1;
        chk("b2b_st_done_req", {31'h0, dmem_req_o}, 32'h0);
        chk("b2b_st_rdata",    rdata_o,             32'h11112222);
        tick();
        #1;
        chk("b2b_idle_a_req", {31'h0, dmem_req_o}, 32'h0);
        tick();
        #1;
        chk("b2b_idle_b_req", {31'h0, dmem_req_o}, 32'h0);

        // Ack while IDLE is ignored
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h31313131;
        tick();
        dmem_ack_i = 1'b0;
        #1;
        chk("stray_ack_rdata", rdata_o,             32'h11112222);
        chk("stray_ack_req",   {31'h0, dmem_req_o}, 32'h0);

        // Reset asserted in 2nd REQ cycle, late ack afterwards
        mem_read_i = 1'b1;
        addr_i = 32'h40;
        tick();
        #1;
        chk("rr_req1", {31'h0, dmem_req_o}, 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop", {31'h0, dmem_req_o}, 32'h0);
        chk("rr_stall",    {31'h0, stall_o},    32'h0);
        chk("rr_addr",     dmem_addr_o,         32'h0);
        chk("rr_rdata",    rdata_o,             32'h0);
        tick();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h99999999;
        mem_read_i = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rr_rel_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("rr_rel_stall", {31'h0, stall_o},    32'h0);
        tick();
        dmem_ack_i = 1'b0;
        #1;
        chk("rr_late_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("rr_late_rdata", rdata_o,             32'h0);

        // Normal load after reset, then read+write together treated as store
        mem_read_i = 1'b1;
        addr_i = 32'h50;
        tick();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h0BADF00D;
        #1;
        chk("pr_ld_req", {31'h0, dmem_req_o}, 32'h1);
        tick();
        dmem_ack_i = 1'b0;
        mem_read_i = 1'b0;
        #1;
        chk("pr_ld_rdata", rdata_o, 32'h0BADF00D);
        tick();
        mem_read_i = 1'b1;
        mem_write_i = 1'b1;
        addr_i = 32'h60;
        wdata_i = 32'h5555AAAA;
        #1;
        chk("rw_idle_stall", {31'h0, stall_o}, 32'h1);
        tick();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h77777777;
        #1;
        chk("rw_we",    {31'h0, dmem_we_o},  32'h1);
        chk("rw_req",   {31'h0, dmem_req_o}, 32'h1);
        chk("rw_wdata", dmem_wdata_o,        32'h5555AAAA);
        tick();
        dmem_ack_i = 1'b0;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        #1;
        chk("rw_done_rdata", rdata_o,             32'h0BADF00D);
        chk("rw_done_req",   {31'h0, dmem_req_o}, 32'h0);
        tick();

`ifdef MEM_TIMEOUT_EN
        // Ack on the 3rd (timeout) REQ cycle wins
        mem_read_i = 1'b1;
        addr_i = 32'h70;
        tick();
        tick();
        tick();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h13579BDF;
        #1;
        chk("to_ack_req", {31'h0, dmem_req_o}, 32'h1);
        tick();
        dmem_ack_i = 1'b0;
        mem_read_i = 1'b0;
        #1;
        chk("to_ack_err",   {31'h0, err_o},   32'h0);
        chk("to_ack_rdata", rdata_o,          32'h13579BDF);
        chk("to_ack_stall", {31'h0, stall_o}, 32'h0);
        tick();

        // No ack: ERR after 3 REQ cycles
        mem_read_i = 1'b1;
        addr_i = 32'h80;
        tick();
        tick();
        tick();
        #1;
        chk("to_req3_req", {31'h0, dmem_req_o}, 32'h1);
        chk("to_req3_err", {31'h0, err_o},      32'h0);
        tick();
        mem_read_i = 1'b0;
        #1;
        chk("to_err_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("to_err_stall", {31'h0, stall_o},    32'h0);
        chk("to_err_err",   {31'h0, err_o},      32'h1);
        chk("to_err_rdata", rdata_o,             32'h0);
        tick();
        #1;
        chk("to_sticky_err", {31'h0, err_o},      32'h1);
        chk("to_idle_req",   {31'h0, dmem_req_o}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("to_rst_err", {31'h0, err_o}, 32'h0);
        tick();
        rst_n = 1'b1;
`else
        // Without timeout support REQ waits indefinitely
        mem_write_i = 1'b1;
        addr_i = 32'h90;
        wdata_i = 32'hFEEDBEEF;
        tick();
        mem_write_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("wait%0d_req", i), {31'h0, dmem_req_o}, 32'h1);
            chk($sformatf("wait%0d_err", i), {31'h0, err_o},      32'h0);
            tick();
        end
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        #1;
        chk("wait_done_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("wait_done_err",   {31'h0, err_o},      32'h0);
        chk("wait_done_rdata", rdata_o,             32'h0BADF00D);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of REQ cycles without an ack before a timeout; legal range 1..255.
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 Port mem_read_i  input  1  SHALL be the MEM-stage read control from the EX/MEM pipeline register.
REQ-005 Port mem_write_i  input  1  SHALL be the MEM-stage write control from the EX/MEM pipeline register.
REQ-006 Port addr_i  input  32  SHALL be the EX/MEM ALU result, used as the byte address.
REQ-007 Port wdata_i  input  32  SHALL be the EX/MEM store data.
REQ-008 Port dmem_req_o / dmem_we_o  output  1 each  SHALL be the registered data-memory request and write enable.
REQ-009 Port dmem_addr_o / dmem_wdata_o  output  32 each  SHALL be the registered address and write data.
REQ-010 Port dmem_ack_i  input  1  SHALL be the data-memory completion; dmem_rdata_i  input  32  SHALL be read data, valid with ack.
REQ-011 Port rdata_o  output  32  SHALL be the captured load data for MEM/WB.
REQ-012 Port stall_o  output  1  SHALL freeze PC, IF/ID, ID/EX and EX/MEM when high.
REQ-013 Port err_o  output  1  SHALL be a sticky timeout flag.

Function
REQ-014 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-015 IDLE: stall_o SHALL be combinationally high when mem_read_i or mem_write_i is high; at the edge, addr/wdata SHALL be latched, dmem_we_o set to mem_write_i, state to REQ.
REQ-016 Both mem_read_i and mem_write_i high SHALL be treated as a write.
REQ-017 REQ: dmem_req_o and stall_o SHALL be high; on dmem_ack_i, rdata_o SHALL capture dmem_rdata_i (reads only) and state SHALL go to DONE.
REQ-018 DONE: stall_o, dmem_req_o SHALL be low for exactly one cycle; inputs SHALL be ignored; next state SHALL be IDLE unconditionally.
REQ-019 dmem_ack_i outside REQ SHALL be ignored.
REQ-020 Minimum access latency SHALL be 3 cycles in MEM (IDLE, REQ with ack, DONE); stall_o high 2 cycles.
REQ-021 A write SHALL leave rdata_o unchanged.
REQ-022 dmem_addr_o/dmem_wdata_o/dmem_we_o SHALL hold stable throughout REQ.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, all outputs 0, counter 0, err_o 0.
REQ-024 Reset during REQ SHALL drop dmem_req_o without waiting for ack; a late ack SHALL be ignored.
REQ-025 First edge after rst_n release SHALL evaluate IDLE normally.

Configuration
REQ-026 Macro MEM_TIMEOUT_EN defined: an 8-bit counter SHALL count REQ cycles, cleared on REQ entry; after TIMEOUT_CYCLES REQ cycles without ack, state SHALL go to ERR.
REQ-027 ERR SHALL behave as DONE with rdata_o = 0 and err_o set until reset; ack arriving on the timeout cycle SHALL win (DONE, no error).
REQ-028 Macro undefined: REQ SHALL wait indefinitely, no counter, no ERR state, err_o tied 0.

Verification
REQ-029 Load addr 0x10, ack on first REQ cycle with rdata 0xCAFE0001 -> stall_o high 2 cycles, rdata_o=0xCAFE0001 in DONE, req high 1 cycle.
REQ-030 Store addr 0x20 data 0x12345678, ack after 4 REQ cycles -> dmem_we_o=1, addr/data stable 4 cycles, stall_o high 5 cycles, rdata_o unchanged.
REQ-031 Back-to-back load then store -> DONE then IDLE then new access; no request dropped or duplicated.
REQ-032 rst_n low in 2nd REQ cycle, ack 1 cycle later -> dmem_req_o=0 immediately, state IDLE, ack ignored.
REQ-033 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=3, no ack -> ERR after 3 REQ cycles, err_o=1 sticky, rdata_o=0; ack on 3rd cycle -> DONE, err_o=0.
REQ-034 Both read and write high, ack immediate -> dmem_we_o=1, rdata_o unchanged.
